lfsr_arbiter: RTL and testbench

Shares a single 16-bit pseudo-random generator between `NUM_REQ` requesters. Arbitration is round-robin. For each granted request the block advances the generator `STEPS` times and presents the resulting word on a valid/ready handshake. It sits between the 16-bit XNOR LFSR datapath, which it embeds and sequences, and the SoC blocks that consume random words, such as test-pattern and scrambler-seed consumers.

---
 rtl/lfsr_arbiter.sv | 152 +++++++++++++++
 tb/tb_lfsr_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_arbiter.sv
// lfsr_arbiter
//
// Shares one 16-bit XNOR LFSR between NUM_REQ requesters. A round-robin
// arbiter picks a requester, the LFSR is advanced STEPS times, and the
// resulting word is offered on a valid/ready handshake.
//
// Ports
//   clk         rising-edge clock
//   reset_n     asynchronous active-low reset
//   req         level-sensitive request lines, one per requester
//   gnt         registered one-hot grant
//   rnd_data    current LFSR register (meaningful while rnd_valid is high)
//   rnd_valid   word available for the granted requester
//   rnd_ready   granted requester accepts the word
//   seed_load   load seed_value into the LFSR (only acted on in IDLE)
//   seed_value  new seed; 16'hFFFF is replaced by 16'h0000
//   busy        high whenever the FSM is not in IDLE
//   fsm_state   debug view of the FSM state (IDLE=0, SHIFT=1, PRESENT=2)
//
// Handshake: a word transfers on the rising edge where rnd_valid and
// rnd_ready are both high. rnd_valid stays high and rnd_data stays stable
// until that edge, unless the granted requester drops its req first, in
// which case the transaction is abandoned and no word is delivered.

module lfsr_arbiter #(
    parameter int          NUM_REQ = 4,
    parameter int          STEPS   = 16,
    parameter logic [15:0] SEED    = 16'h0000
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [15:0]        rnd_data,
    output logic               rnd_valid,
    input  logic               rnd_ready,
    input  logic               seed_load,
    input  logic [15:0]        seed_value,
    output logic               busy,
    output logic [1:0]         fsm_state
);

    localparam int IDXW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        PRESENT = 2'd2
    } state_t;

    state_t             state, state_nx;
    logic [15:0]        lfsr, lfsr_nx;
    logic [7:0]         cnt, cnt_nx;
    logic [NUM_REQ-1:0] gnt_nx;
    logic [IDXW-1:0]    cur_idx, cur_idx_nx;
    logic [IDXW-1:0]    last_idx, last_idx_nx;

    logic               found;
    logic [IDXW-1:0]    pick;
    logic [IDXW-1:0]    cand;
    logic [15:0]        lfsr_step;

    assign lfsr_step = {lfsr[14:0], ~(lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10])};

    // Round-robin search: first set req bit starting just above last grant.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = IDXW'((int'(last_idx) + i) % NUM_REQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        state_nx    = state;
        lfsr_nx     = lfsr;
        cnt_nx      = cnt;
        gnt_nx      = gnt;
        cur_idx_nx  = cur_idx;
        last_idx_nx = last_idx;
        unique case (state)
            IDLE: begin
                if (seed_load) begin
                    // All-ones is the XNOR lock-up value; substitute zero.
                    lfsr_nx = (seed_value == 16'hFFFF) ? 16'h0000 : seed_value;
                end else if (found) begin
                    gnt_nx       = '0;
                    gnt_nx[pick] = 1'b1;
                    cur_idx_nx   = pick;
                    cnt_nx       = 8'(STEPS);
                    state_nx     = SHIFT;
                end
            end
            SHIFT: begin
                if (!req[cur_idx]) begin
                    // Abort: keep the partially advanced LFSR value.
                    gnt_nx      = '0;
                    last_idx_nx = cur_idx;
                    state_nx    = IDLE;
                end else begin
                    lfsr_nx = lfsr_step;
                    cnt_nx  = cnt - 8'd1;
                    if (cnt == 8'd1) begin
                        state_nx = PRESENT;
                    end
                end
            end
            PRESENT: begin
                // Abort and completed handshake leave the same state behind;
                // the difference is only whether the requester took the word.
                if (!req[cur_idx] || rnd_ready) begin
                    gnt_nx      = '0;
                    last_idx_nx = cur_idx;
                    state_nx    = IDLE;
                end
            end
            default: begin
                gnt_nx   = '0;
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            lfsr     <= SEED;
            cnt      <= 8'd0;
            gnt      <= '0;
            cur_idx  <= '0;
            last_idx <= IDXW'(NUM_REQ - 1);
        end else begin
            state    <= state_nx;
            lfsr     <= lfsr_nx;
            cnt      <= cnt_nx;
            gnt      <= gnt_nx;
            cur_idx  <= cur_idx_nx;
            last_idx <= last_idx_nx;
        end
    end

    assign rnd_data  = lfsr;
    assign rnd_valid = (state == PRESENT);
    assign busy      = (state != IDLE);
    assign fsm_state = state;

endmodule

// File: tb/tb_lfsr_arbiter.sv
module tb_lfsr_arbiter;

    localparam int          NUM_REQ = 4;
    localparam int          STEPS   = 4;
    localparam logic [15:0] SEED    = 16'h0000;

    logic               clk;
    logic               reset_n;
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] gnt;
    logic [15:0]        rnd_data;
    logic               rnd_valid;
    logic               rnd_ready;
    logic               seed_load;
    logic [15:0]        seed_value;
    logic               busy;
    logic [1:0]         fsm_state;

    int n_vec = 0;
    int n_err = 0;

    lfsr_arbiter #(.NUM_REQ(NUM_REQ), .STEPS(STEPS), .SEED(SEED)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req        (req),
        .gnt        (gnt),
        .rnd_data   (rnd_data),
        .rnd_valid  (rnd_valid),
        .rnd_ready  (rnd_ready),
        .seed_load  (seed_load),
        .seed_value (seed_value),
        .busy       (busy),
        .fsm_state  (fsm_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[14:0], ~(v[15] ^ v[13] ^ v[12] ^ v[10])};
    endfunction

    function automatic logic [15:0] lfsr_adv(input logic [15:0] v, input int n);
        logic [15:0] r = v;
        for (int k = 0; k < n; k++) r = lfsr_next(r);
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: timed out, got 0, expected 1", name);
    endtask

    // Advance one clock; outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n    = 1'b0;
        req        = '0;
        rnd_ready  = 1'b0;
        seed_load  = 1'b0;
        seed_value = 16'h0000;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [3:0]  req;
        logic        rdy;
        logic        sl;
        logic [15:0] sv;
        logic [3:0]  g;
        logic        v;
        logic        b;
        logic [15:0] d;
    } vec_t;

    vec_t vecs[26];

    initial begin
        //            req      rdy sl   seed      gnt     v  b  data
        vecs[0]  = '{4'b0001, 0, 0, 16'h0000, 4'b0001, 0, 1, 16'h0000};
        vecs[1]  = '{4'b0001, 0, 0, 16'h0000, 4'b0001, 0, 1, 16'h0001};
        vecs[2]  = '{4'b0001, 0, 0, 16'h0000, 4'b0001, 0, 1, 16'h0003};
        vecs[3]  = '{4'b0001, 0, 0, 16'h0000, 4'b0001, 0, 1, 16'h0007};
        vecs[4]  = '{4'b0001, 0, 0, 16'h0000, 4'b0001, 1, 1, 16'h000F};
        vecs[5]  = '{4'b0001, 1, 0, 16'h0000, 4'b0000, 0, 0, 16'h000F};
        vecs[6]  = '{4'b0001, 1, 0, 16'h0000, 4'b0001, 0, 1, 16'h000F};
        vecs[7]  = '{4'b0001, 1, 0, 16'h0000, 4'b0001, 0, 1, 16'h001F};
        vecs[8]  = '{4'b0001, 1, 0, 16'h0000, 4'b0001, 0, 1, 16'h003F};
        vecs[9]  = '{4'b0001, 1, 0, 16'h0000, 4'b0001, 0, 1, 16'h007F};
        vecs[10] = '{4'b0001, 1, 0, 16'h0000, 4'b0001, 1, 1, 16'h00FF};
        vecs[11] = '{4'b0001, 1, 0, 16'h0000, 4'b0000, 0, 0, 16'h00FF};
        vecs[12] = '{4'b0010, 0, 1, 16'h0001, 4'b0000, 0, 0, 16'h0001};
        vecs[13] = '{4'b0010, 0, 0, 16'h0000, 4'b0010, 0, 1, 16'h0001};
        vecs[14] = '{4'b0010, 0, 0, 16'h0000, 4'b0010, 0, 1, 16'h0003};
        vecs[15] = '{4'b0010, 0, 0, 16'h0000, 4'b0010, 0, 1, 16'h0007};
        vecs[16] = '{4'b0010, 0, 0, 16'h0000, 4'b0010, 0, 1, 16'h000F};
        vecs[17] = '{4'b0010, 0, 0, 16'h0000, 4'b0010, 1, 1, 16'h001F};
        vecs[18] = '{4'b0010, 1, 0, 16'h0000, 4'b0000, 0, 0, 16'h001F};
        vecs[19] = '{4'b0000, 0, 1, 16'hFFFF, 4'b0000, 0, 0, 16'h0000};
        vecs[20] = '{4'b0100, 0, 0, 16'h0000, 4'b0100, 0, 1, 16'h0000};
        vecs[21] = '{4'b0100, 0, 1, 16'h1234, 4'b0100, 0, 1, 16'h0001};
        vecs[22] = '{4'b0100, 0, 0, 16'h0000, 4'b0100, 0, 1, 16'h0003};
        vecs[23] = '{4'b0100, 0, 0, 16'h0000, 4'b0100, 0, 1, 16'h0007};
        vecs[24] = '{4'b0100, 0, 0, 16'h0000, 4'b0100, 1, 1, 16'h000F};
        vecs[25] = '{4'b0000, 1, 0, 16'h0000, 4'b0000, 0, 0, 16'h000F};
    end

    // ---------------- reference model ----------------
    // Transaction-level view: who owns the generator and how many shifts
    // that owner has received so far.
    logic [15:0] m_lfsr;
    int          m_owner;
    int          m_done;
    int          m_last;

    task automatic model_reset();
        m_lfsr  = SEED;
        m_owner = -1;
        m_done  = 0;
        m_last  = NUM_REQ - 1;
    endtask

    function automatic int rr_pick(input logic [NUM_REQ-1:0] r, input int last);
        for (int k = 1; k <= NUM_REQ; k++)
            if (r[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
        return -1;
    endfunction

    task automatic model_edge();
        if (m_owner < 0) begin
            if (seed_load) m_lfsr = (seed_value == 16'hFFFF) ? 16'h0000 : seed_value;
            else begin
                m_owner = rr_pick(req, m_last);
                m_done  = 0;
            end
        end else if (!req[m_owner] || (m_done == STEPS && rnd_ready)) begin
            m_last  = m_owner;
            m_owner = -1;
        end else if (m_done < STEPS) begin
            m_lfsr = lfsr_next(m_lfsr);
            m_done++;
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin : main
        logic [15:0] exp_word;
        logic [3:0]  order[5];
        int          budget;
        order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100;
        order[3] = 4'b1000; order[4] = 4'b0001;

        do_reset();
        check("reset_gnt", 32'(gnt), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_valid", 32'(rnd_valid), 32'h0);
        check("reset_data", 32'(rnd_data), 32'(SEED));

        // Table: basic flow, back-to-back word, seed loads.
        for (int i = 0; i < 26; i++) begin
            req        = vecs[i].req;
            rnd_ready  = vecs[i].rdy;
            seed_load  = vecs[i].sl;
            seed_value = vecs[i].sv;
            tick();
            check($sformatf("vec%0d_gnt", i), 32'(gnt), 32'(vecs[i].g));
            check($sformatf("vec%0d_valid", i), 32'(rnd_valid), 32'(vecs[i].v));
            check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].b));
            check($sformatf("vec%0d_data", i), 32'(rnd_data), 32'(vecs[i].d));
        end

        // Round-robin fairness with all requests held and ready high.
        do_reset();
        seed_load = 1'b0;
        req       = 4'b1111;
        rnd_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            budget = 0;
            do begin tick(); budget++; end while (gnt == '0 && budget < 20);
            if (gnt == '0) timeout($sformatf("rr%0d_grant", k));
            check($sformatf("rr%0d_gnt", k), 32'(gnt), 32'(order[k]));
            budget = 0;
            while (!rnd_valid && budget < 20) begin tick(); budget++; end
            if (!rnd_valid) timeout($sformatf("rr%0d_valid", k));
            check($sformatf("rr%0d_data", k), 32'(rnd_data), 32'(lfsr_adv(SEED, STEPS * (k + 1))));
            tick();
            check($sformatf("rr%0d_done", k), 32'(gnt), 32'h0);
        end

        // Backpressure: word and grant stay stable while ready is low.
        req       = 4'b0010;
        rnd_ready = 1'b0;
        budget    = 0;
        while (!rnd_valid && budget < 20) begin tick(); budget++; end
        if (!rnd_valid) timeout("bp_valid");
        exp_word = lfsr_adv(SEED, STEPS * 6);
        for (int k = 0; k < 10; k++) begin
            tick();
            check($sformatf("bp%0d_valid", k), 32'(rnd_valid), 32'h1);
            check($sformatf("bp%0d_data", k), 32'(rnd_data), 32'(exp_word));
            check($sformatf("bp%0d_gnt", k), 32'(gnt), 32'(4'b0010));
        end
        rnd_ready = 1'b1;
        tick();
        rnd_ready = 1'b0;
        req       = '0;
        check("bp_release_valid", 32'(rnd_valid), 32'h0);
        check("bp_release_busy", 32'(busy), 32'h0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("bp_after%0d_valid", k), 32'(rnd_valid), 32'h0);
        end

        // Abort after 2 of 4 shifts.
        do_reset();
        req = 4'b0001;
        tick();
        check("abort_gnt", 32'(gnt), 32'(4'b0001));
        tick();
        check("abort_s1_valid", 32'(rnd_valid), 32'h0);
        tick();
        check("abort_s2_valid", 32'(rnd_valid), 32'h0);
        req = 4'b0000;
        tick();
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_gnt_clr", 32'(gnt), 32'h0);
        check("abort_valid", 32'(rnd_valid), 32'h0);
        check("abort_data", 32'(rnd_data), 32'h0003);
        req = 4'b1111;
        tick();
        check("abort_next_gnt", 32'(gnt), 32'(4'b0010));
        tick();

        // Asynchronous reset mid-SHIFT, checked before any clock edge.
        #2;
        reset_n = 1'b0;
        #1;
        check("areset_gnt", 32'(gnt), 32'h0);
        check("areset_busy", 32'(busy), 32'h0);
        check("areset_valid", 32'(rnd_valid), 32'h0);
        check("areset_data", 32'(rnd_data), 32'(SEED));

        // Randomized traffic against the transaction-level model.
        do_reset();
        model_reset();
        req = 4'($urandom_range(0, 15));
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 7) == 0) req = 4'($urandom_range(0, 15));
            rnd_ready  = ($urandom_range(0, 1) == 1);
            seed_load  = ($urandom_range(0, 9) == 0);
            seed_value = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom_range(0, 65535));
            model_edge();
            tick();
            check($sformatf("rand%0d_gnt", c), 32'(gnt),
                  (m_owner < 0) ? 32'h0 : (32'h1 << m_owner));
            check($sformatf("rand%0d_valid", c), 32'(rnd_valid),
                  32'((m_owner >= 0) && (m_done == STEPS)));
            check($sformatf("rand%0d_busy", c), 32'(busy), 32'(m_owner >= 0));
            check($sformatf("rand%0d_data", c), 32'(rnd_data), 32'(m_lfsr));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
